ibex_fetch_realign_fifo: RTL and testbench
==========================================

// Module: ibex_fetch_realign_fifo
//
// PURPOSE
// Word-granular instruction FIFO between the instruction-bus response path and the IF stage.
// Buffers 32-bit fetch responses and realigns them into one instruction per handshake,
// handling 16-bit compressed and halfword-misaligned 32-bit instructions.
// Supplies the IF stage with instruction data, PC and the err / err_plus2 fault flags.
// Has a zero-latency bypass when empty; flushed and re-pointed on every branch.
//
// PARAMETERS
// DEPTH  3  number of 32-bit entries (>=2); data+err stored per entry
//
// PORTS
// clk_i            in   1   clock
// rst_ni           in   1   reset, asynchronous, active-low
// clear_i          in   1   flush all entries; load instruction address from addr_i
// addr_i           in   32  new instruction address on clear_i; bit 0 ignored (treated 0)
// in_valid_i       in   1   fetch response word valid this cycle (no ready; see full rules)
// in_rdata_i       in   32  fetch response word (address word-aligned by upstream)
// in_err_i         in   1   bus/PMP error on this response word
// out_valid_o      out  1   instruction available to IF stage
// out_ready_i      in   1   IF stage accepts instruction
// out_rdata_o      out  32  instruction bits (compressed in [15:0], upper bits don't-care)
// out_addr_o       out  32  PC of out_rdata_o
// out_err_o        out  1   fetch error on this instruction
// out_err_plus2_o  out  1   error is in second halfword only (misaligned 32-bit instr)
// busy_o           out  1   occupancy >= DEPTH-1; upstream must not issue new requests
//
// BEHAVIOUR
// - Reset: FIFO empty, instr_addr_q=0, out_valid_o=0, out_err_o=0, out_err_plus2_o=0, busy_o=0.
// - View = stored entries (oldest first) followed by in_rdata_i when in_valid_i (bypass).
//   W0/W1 = first/second word of view. aligned = instr_addr_q[1]==0.
// - Aligned: valid iff W0 exists. rdata=W0; err=err(W0); err_plus2=0.
// - Misaligned: lo=W0[31:16]. Compressed (lo[1:0]!=2'b11) or err(W0): valid iff W0 exists,
//   rdata={16'h0,lo}, err=err(W0). Else valid iff W1 exists, rdata={W1[15:0],lo},
//   err=err(W0)|err(W1), err_plus2=err(W1)&~err(W0).
// - Compressed test is on the output halfword's [1:0]!=2'b11; an errored instruction
//   is treated as 32-bit for addressing.
// - On out_valid_o&out_ready_i: aligned compressed -> addr+=2, no pop; aligned 32-bit -> addr+=4,
//   pop 1; misaligned compressed -> addr+=2, pop 1; misaligned 32-bit -> addr+=4, pop 1.
//   Address arithmetic is 32-bit modulo (0xFFFF_FFFE+2 wraps to 0).
// - Pop of a word supplied via bypass means it is not written; otherwise in_valid_i writes at tail.
//   Simultaneous push+pop leaves count unchanged.
// - out_addr_o = instr_addr_q; outputs are combinational from view, no added latency.
// - clear_i: next cycle count=0, instr_addr_q={addr_i[31:1],1'b0}; same-cycle in_valid_i
//   discarded; out_valid_o forced 0 while clear_i=1; clear wins over every other event.
// - Full: in_valid_i when count==DEPTH and no pop is a protocol error (assertion); the word is dropped.
// - busy_o registered-count based: (count >= DEPTH-1); does not depend on out_ready_i.
// - Reset asserted mid-operation discards all entries immediately (async).
//
// TESTING
// 1 clear addr=0x100; push 0x00A3_0313 -> same cycle valid, rdata=0x00A30313, addr=0x100; ready -> addr 0x104.
// 2 clear addr=0x200; push 0x4505_4501 -> two compressed: rdata[15:0]=0x4501@0x200 then 0x4505@0x202, one pop.
// 3 clear addr=0x302; push 0x0513_xxxx, no 2nd word -> valid=0; push 0x0000_00A0 -> rdata=0x00A00513 @0x302.
// 4 misaligned 32-bit, W0 ok, W1 err=1 -> out_err_o=1, out_err_plus2_o=1; W0 err -> err_plus2=0.
// 5 out_ready_i=0, push 3 words (DEPTH=3) -> busy_o=1 after 2nd; clear_i with in_valid_i -> empty, valid=0.
// 6 addr=0xFFFF_FFFC, 32-bit instr consumed -> out_addr_o wraps to 0x0000_0000.

Source files
------------

// File: rtl/ibex_fetch_realign_fifo.sv
// Word-granular fetch FIFO that realigns 32-bit bus words into one instruction per handshake.
// Latency: zero; an empty FIFO bypasses the incoming word straight to the IF stage.
// Backpressure: no input ready; upstream throttles on busy_o, and out_ready_i holds the output.
module ibex_fetch_realign_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Entry 0 is always the oldest word; a pop shifts the array down by one.
  logic [31:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_err;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_addr;

  logic           w_w0_vld, w_w1_vld;
  logic [31:0]    w_w0, w_w1;
  logic           w_e0, w_e1;
  logic [15:0]    w_lo;
  logic           w_pop_req;
  logic           w_len4;
  logic           w_fire, w_pop, w_pop_stored, w_push;
  logic [CW-1:0]  w_widx;

  // The view is the stored words followed by the incoming word when it is valid.
  assign w_w0_vld = (r_count != '0) | in_valid_i;
  assign w_w0     = (r_count != '0) ? r_mem[0] : in_rdata_i;
  assign w_e0     = (r_count != '0) ? r_err[0] : in_err_i;
  assign w_w1_vld = (r_count >= CW'(2)) | ((r_count == CW'(1)) & in_valid_i);
  assign w_w1     = (r_count >= CW'(2)) ? r_mem[1] : in_rdata_i;
  assign w_e1     = (r_count >= CW'(2)) ? r_err[1] : in_err_i;
  assign w_lo     = w_w0[31:16];

  // Realign the view into one instruction; errored instructions advance the PC by 4.
  always_comb begin
    out_valid_o     = 1'b0;
    out_rdata_o     = w_w0;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;
    w_pop_req       = 1'b0;
    w_len4          = 1'b0;
    if (!r_addr[1]) begin
      out_valid_o = w_w0_vld;
      out_err_o   = w_e0;
      w_len4      = (w_w0[1:0] == 2'b11) | w_e0;
      w_pop_req   = w_len4;
    end else if ((w_lo[1:0] != 2'b11) || w_e0) begin
      out_valid_o = w_w0_vld;
      out_rdata_o = {16'h0000, w_lo};
      out_err_o   = w_e0;
      w_len4      = w_e0;
      w_pop_req   = 1'b1;
    end else begin
      out_valid_o     = w_w1_vld;
      out_rdata_o     = {w_w1[15:0], w_lo};
      out_err_o       = w_e0 | w_e1;
      out_err_plus2_o = w_e1 & ~w_e0;
      w_len4          = 1'b1;
      w_pop_req       = 1'b1;
    end
    if (clear_i) begin
      out_valid_o = 1'b0;
    end
    if (!out_valid_o) begin
      out_err_o       = 1'b0;
      out_err_plus2_o = 1'b0;
    end
  end

  // A popped bypass word is never written; a full FIFO without a pop drops the input word.
  assign w_fire       = out_valid_o & out_ready_i;
  assign w_pop        = w_fire & w_pop_req;
  assign w_pop_stored = w_pop & (r_count != '0);
  assign w_push       = in_valid_i & ~clear_i & ~(w_pop & (r_count == '0)) &
                        (w_pop_stored | (r_count != CW'(DEPTH)));
  assign w_widx       = r_count - CW'(w_pop_stored);

  assign out_addr_o = r_addr;
  assign busy_o     = (r_count >= CW'(DEPTH - 1));

  // Occupancy and instruction address; clear overrides every other event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_addr  <= 32'h0;
    end else if (clear_i) begin
      r_count <= '0;
      r_addr  <= {addr_i[31:1], 1'b0};
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop_stored);
      if (w_fire) begin
        r_addr <= r_addr + (w_len4 ? 32'd4 : 32'd2);
      end
    end
  end

  // Word storage: shift down on pop, then write the incoming word at the new tail.
  always_ff @(posedge clk_i) begin
    if (w_pop_stored) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_mem[i] <= r_mem[i+1];
        r_err[i] <= r_err[i+1];
      end
    end
    if (w_push) begin
      r_mem[w_widx] <= in_rdata_i;
      r_err[w_widx] <= in_err_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && !w_pop_stored && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_ibex_fetch_realign_fifo.sv
// Scoreboard bench for the fetch realign FIFO against a word-queue reference model.
// Latency: expectations are computed per cycle and checked on the following falling edge.
// Backpressure: out_ready_i is randomised; in_valid_i is only issued while the model has room.
module tb_ibex_fetch_realign_fifo;

  localparam int unsigned DEPTH = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_rdata_i = '0;
  logic        in_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_err_plus2_o;
  logic        busy_o;

  ibex_fetch_realign_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .addr_i          (addr_i),
    .in_valid_i      (in_valid_i),
    .in_rdata_i      (in_rdata_i),
    .in_err_i        (in_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_rdata_o     (out_rdata_o),
    .out_addr_o      (out_addr_o),
    .out_err_o       (out_err_o),
    .out_err_plus2_o (out_err_plus2_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic        p2;
    logic        busy;
  } exp_t;

  exp_t        sb[$];
  logic [32:0] mq[$];     // model storage: {err, word}, oldest first
  logic [31:0] maddr = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict the DUT response from the model, then advance the model.
  task automatic step(input logic clr, input logic [31:0] a, input logic iv,
                      input logic [31:0] d, input logic e, input logic rdy);
    logic [32:0] v[$];
    exp_t        x;
    logic [31:0] w0, w1;
    logic [15:0] lo;
    logic        e0, e1, pop;
    int          len;
    @(posedge clk_i);
    #1;
    clear_i = clr; addr_i = a; in_valid_i = iv; in_rdata_i = d; in_err_i = e; out_ready_i = rdy;
    v = mq;
    if (iv) v.push_back({e, d});
    x.valid = 1'b0; x.rdata = '0; x.err = 1'b0; x.p2 = 1'b0;
    x.addr = maddr; x.busy = (mq.size() >= DEPTH - 1);
    pop = 1'b0; len = 0;
    if (v.size() > 0) begin
      w0 = v[0][31:0]; e0 = v[0][32]; lo = w0[31:16];
      if (maddr[1] == 1'b0) begin
        x.valid = 1'b1; x.rdata = w0; x.err = e0;
        if (w0[1:0] != 2'b11 && !e0) len = 2;
        else begin len = 4; pop = 1'b1; end
      end else if (lo[1:0] != 2'b11 || e0) begin
        x.valid = 1'b1; x.rdata = {16'h0, lo}; x.err = e0;
        len = e0 ? 4 : 2; pop = 1'b1;
      end else if (v.size() > 1) begin
        w1 = v[1][31:0]; e1 = v[1][32];
        x.valid = 1'b1; x.rdata = {w1[15:0], lo};
        x.err = e0 | e1; x.p2 = e1 & ~e0;
        len = 4; pop = 1'b1;
      end
    end
    if (clr) x.valid = 1'b0;
    sb.push_back(x);
    if (clr) begin
      mq.delete();
      maddr = {a[31:1], 1'b0};
    end else begin
      if (x.valid && rdy) begin
        if (pop) void'(v.pop_front());
        maddr = maddr + 32'(len);
      end
      mq = v;
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic rdy);
    step(1'b0, 32'h0, 1'b1, d, e, rdy);
  endtask

  task automatic clr(input logic [31:0] a);
    step(1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every predicted cycle on the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("out_valid", 32'(out_valid_o), 32'(x.valid));
        chk("out_addr", out_addr_o, x.addr);
        chk("busy", 32'(busy_o), 32'(x.busy));
        if (x.valid) begin
          chk("out_rdata", out_rdata_o, x.rdata);
          chk("out_err", 32'(out_err_o), 32'(x.err));
          chk("out_err_plus2", 32'(out_err_plus2_o), 32'(x.p2));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        iv, e, rdy;
    logic [31:0] d;
    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_addr", out_addr_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(out_err_o), 32'h0);
    chk("rst_err_plus2", 32'(out_err_plus2_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Aligned 32-bit bypass
    clr(32'h100); push(32'h00A3_0313, 1'b0, 1'b1); idle(1'b1);
    // Two compressed in one word
    clr(32'h200); push(32'h4505_4501, 1'b0, 1'b1); idle(1'b1); idle(1'b1);
    // Misaligned 32-bit spanning two words
    clr(32'h302); push(32'h0513_ABCD, 1'b0, 1'b1); push(32'h0000_00A0, 1'b0, 1'b1); idle(1'b0);
    // Error in second halfword only, then error in first word
    clr(32'h2); push(32'h0003_0000, 1'b0, 1'b0); push(32'h0000_0001, 1'b1, 1'b1); idle(1'b1);
    clr(32'h2); push(32'h0003_0000, 1'b1, 1'b1); idle(1'b1);
    // Fill to DEPTH with no consumer, then clear with a simultaneous input word
    clr(32'h0);
    push(32'h1111_0003, 1'b0, 1'b0); push(32'h2222_0003, 1'b0, 1'b0);
    push(32'h3333_0003, 1'b0, 1'b0); idle(1'b0);
    step(1'b1, 32'h40, 1'b1, 32'h4444_0003, 1'b0, 1'b1); idle(1'b1);
    // Address wrap
    clr(32'hFFFF_FFFC); push(32'h0000_0013, 1'b0, 1'b1); idle(1'b1);
    clr(32'hFFFF_FFFE); push(32'h0001_0001, 1'b0, 1'b1); idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 | (d & 32'hE);
        clr(d);
      end else begin
        iv  = (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
        d   = $urandom;
        e   = ($urandom_range(0, 7) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        step(1'b0, 32'h0, iv, d, e, rdy);
      end
    end

    // Asynchronous reset in the middle of a cycle with words stored
    clr(32'h500);
    push(32'h0000_0003, 1'b0, 1'b0); push(32'h0000_0003, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
    in_valid_i = 1'b0; clear_i = 1'b0; out_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_addr", out_addr_o, 32'h0);
    mq.delete();
    maddr = 32'h0;
    #2;
    rst_ni = 1'b1;
    idle(1'b1); push(32'h0000_4501, 1'b0, 1'b1); idle(1'b1);

    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
